// File: rtl/stack_param.sv
// Parametrised LIFO operand stack with occupancy tracking, sticky error flags and a peek port.
// Commands are decoded from {load, push, pop}, and every update lands on the rising clock edge.
module stack_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 6,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  input  logic [IW-1:0]    pidx,
  output logic [WIDTH-1:0] qtop,
  output logic [WIDTH-1:0] qnext,
  output logic [WIDTH-1:0] qpeek,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf,
  output logic             err_op
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] q     [DEPTH];
  logic [WIDTH-1:0] q_nxt [DEPTH];
  logic [CW-1:0]    count_nxt;
  logic             ovf_nxt, udf_nxt, err_nxt;

  always_comb begin
    q_nxt     = q;
    count_nxt = count;
    ovf_nxt   = ovf;
    udf_nxt   = udf;
    err_nxt   = err_op;
    case ({load, push, pop})
      3'b100: begin
        q_nxt[0] = d;
        if (count == '0) count_nxt = ONE_CNT;
      end
      3'b010, 3'b110: begin
        for (int i = 1; i < DEPTH; i++) q_nxt[i] = q[i-1];
        if (load) q_nxt[0] = d;
        if (count == FULL_CNT) ovf_nxt = 1'b1;
        else count_nxt = count + ONE_CNT;
      end
      3'b001: begin
        if (count == '0) begin
          udf_nxt = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH - 1; i++) q_nxt[i] = q[i+1];
          q_nxt[DEPTH-1] = '0;
          count_nxt = count - ONE_CNT;
        end
      end
      3'b101: begin
        q_nxt[0] = d;
        // Fewer than two operands: keep the result on top without shifting.
        if (count < CW'(2)) begin
          count_nxt = ONE_CNT;
          udf_nxt   = 1'b1;
        end else begin
          for (int i = 1; i < DEPTH - 1; i++) q_nxt[i] = q[i+1];
          q_nxt[DEPTH-1] = '0;
          count_nxt = count - ONE_CNT;
        end
      end
      3'b011, 3'b111: err_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      err_op <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      err_op <= 1'b0;
    end else begin
      q      <= q_nxt;
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      udf    <= udf_nxt;
      err_op <= err_nxt;
    end
  end

  always_comb begin
    qpeek = '0;
    if (32'(pidx) < DEPTH) qpeek = q[pidx];
  end

  assign qtop  = q[0];
  assign qnext = q[1];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: tb/tb_stack_param.sv
// Directed bench for stack_param at WIDTH=16, DEPTH=6.
// Each scenario task drives its commands and compares the outputs against hand-computed values.
module tb_stack_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, load, push, pop;
  logic [15:0] d;
  logic [2:0]  pidx;
  logic [15:0] qtop, qnext, qpeek;
  logic [2:0]  count;
  logic        empty, full, ovf, udf, err_op;

  int compared = 0;
  int mismatched = 0;

  stack_param #(.WIDTH(16), .DEPTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .push(push), .pop(pop),
    .d(d), .pidx(pidx), .qtop(qtop), .qnext(qnext), .qpeek(qpeek),
    .count(count), .empty(empty), .full(full), .ovf(ovf), .udf(udf), .err_op(err_op)
  );

  always #5 clk = ~clk;

  // Apply one command for one clock and return 1ns after the edge.
  task automatic step(input logic l, input logic p, input logic o, input logic [15:0] dv);
    load = l; push = p; pop = o; d = dv;
    @(posedge clk);
    #1;
    load = 1'b0; push = 1'b0; pop = 1'b0; d = 16'h0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; push = 1'b0; pop = 1'b0; d = 16'h0; pidx = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compared++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || qtop !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: count=%0d empty=%b full=%b qtop=%h, want 0 1 0 0000", count, empty, full, qtop);
    end
    compared++;
    if ({ovf, udf, err_op} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b want 000", {ovf, udf, err_op});
    end
    step(1, 1, 0, 16'h11);
    step(1, 1, 0, 16'h22);
    step(1, 1, 0, 16'h33);
    compared++;
    if (count !== 3'd3 || qtop !== 16'h33) begin
      mismatched++;
      $display("[TB] FAIL pre_async: count=%0d qtop=%h want 3 0033", count, qtop);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (count !== 3'd0 || empty !== 1'b1 || qtop !== 16'h0 || qnext !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: count=%0d empty=%b qtop=%h qnext=%h want 0 1 0000 0000", count, empty, qtop, qnext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clear();
    step(1, 1, 0, 16'h44);
    step(1, 1, 0, 16'h55);
    clr = 1'b1; push = 1'b1; load = 1'b1; d = 16'h66;
    @(posedge clk);
    #1;
    clr = 1'b0; push = 1'b0; load = 1'b0;
    compared++;
    if (count !== 3'd0 || empty !== 1'b1 || qtop !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL clr_wins: count=%0d empty=%b qtop=%h want 0 1 0000", count, empty, qtop);
    end
  endtask

  task automatic fill_1_to_6();
    for (int i = 1; i <= 6; i++) step(1, 1, 0, 16'(i));
  endtask

  task automatic test_push_fill();
    do_clr();
    fill_1_to_6();
    pidx = 3'd5;
    #1;
    compared++;
    if (qtop !== 16'd6 || qnext !== 16'd5 || qpeek !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL fill_data: qtop=%0d qnext=%0d qpeek5=%0d want 6 5 1", qtop, qnext, qpeek);
    end
    compared++;
    if (count !== 3'd6 || full !== 1'b1 || ovf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fill_count: count=%0d full=%b ovf=%b want 6 1 0", count, full, ovf);
    end
    step(1, 1, 0, 16'd7);
    compared++;
    if (qtop !== 16'd7 || qpeek !== 16'd2 || count !== 3'd6 || ovf !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL overflow: qtop=%0d qpeek5=%0d count=%0d ovf=%b want 7 2 6 1", qtop, qpeek, count, ovf);
    end
    pidx = 3'd6;
    #1;
    compared++;
    if (qpeek !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL peek_oob: got %h want 0000", qpeek);
    end
    pidx = 3'd2;
    #1;
    compared++;
    if (qpeek !== 16'd5) begin
      mismatched++;
      $display("[TB] FAIL peek_mid: got %0d want 5", qpeek);
    end
  endtask

  task automatic test_pop_drain();
    do_clr();
    fill_1_to_6();
    pidx = 3'd5;
    for (int k = 0; k < 6; k++) begin
      compared++;
      if (qtop !== 16'(6 - k)) begin
        mismatched++;
        $display("[TB] FAIL drain_top%0d: got %0d want %0d", k, qtop, 6 - k);
      end
      step(0, 0, 1, 16'h0);
      if (k == 0) begin
        compared++;
        if (qpeek !== 16'h0 || count !== 3'd5) begin
          mismatched++;
          $display("[TB] FAIL first_pop: qpeek5=%0d count=%0d want 0 5", qpeek, count);
        end
      end
    end
    compared++;
    if (count !== 3'd0 || empty !== 1'b1 || udf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL drained: count=%0d empty=%b udf=%b want 0 1 0", count, empty, udf);
    end
    step(0, 0, 1, 16'h0);
    compared++;
    if (count !== 3'd0 || qtop !== 16'h0 || udf !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pop_underflow: count=%0d qtop=%0d udf=%b want 0 0 1", count, qtop, udf);
    end
  endtask

  task automatic test_binary();
    do_clr();
    step(1, 1, 0, 16'd3);
    step(1, 1, 0, 16'd4);
    step(1, 0, 1, 16'd7);
    compared++;
    if (qtop !== 16'd7 || qnext !== 16'd0 || count !== 3'd1 || udf !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL binop: qtop=%0d qnext=%0d count=%0d udf=%b want 7 0 1 0", qtop, qnext, count, udf);
    end
    step(1, 0, 1, 16'd9);
    compared++;
    if (qtop !== 16'd9 || count !== 3'd1 || udf !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL binop_underflow: qtop=%0d count=%0d udf=%b want 9 1 1", qtop, count, udf);
    end
  endtask

  task automatic test_dup_load();
    do_clr();
    step(1, 1, 0, 16'h00AA);
    step(0, 1, 0, 16'h0);
    compared++;
    if (qtop !== 16'h00AA || qnext !== 16'h00AA || count !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL dup: qtop=%h qnext=%h count=%0d want 00aa 00aa 2", qtop, qnext, count);
    end
    step(1, 0, 0, 16'h0055);
    compared++;
    if (qtop !== 16'h0055 || qnext !== 16'h00AA || count !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL load: qtop=%h qnext=%h count=%0d want 0055 00aa 2", qtop, qnext, count);
    end
  endtask

  task automatic test_illegal();
    step(0, 1, 1, 16'h0);
    compared++;
    if (qtop !== 16'h0055 || qnext !== 16'h00AA || count !== 3'd2 || err_op !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL illegal: qtop=%h qnext=%h count=%0d err=%b want 0055 00aa 2 1", qtop, qnext, count, err_op);
    end
    step(1, 1, 0, 16'h0001);
    step(0, 0, 1, 16'h0);
    compared++;
    if (err_op !== 1'b1 || count !== 3'd2 || qtop !== 16'h0055) begin
      mismatched++;
      $display("[TB] FAIL err_sticky: err=%b count=%0d qtop=%h want 1 2 0055", err_op, count, qtop);
    end
    do_clr();
    compared++;
    if (err_op !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL err_clear: got %b want 0", err_op);
    end
  endtask

  task automatic test_dup_empty();
    do_clr();
    step(1, 0, 0, 16'h0BEE);
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'h0);
    compared++;
    if (count !== 3'd1 || {ovf, udf, err_op} !== 3'b000 || qtop !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL dup_empty: count=%0d flags=%b qtop=%h want 1 000 0000", count, {ovf, udf, err_op}, qtop);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_push_fill();
    test_pop_drain();
    test_binary();
    test_dup_load();
    test_illegal();
    test_dup_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
